// File: rtl/rd_stream_out_stage.sv
// Read-side output stage: buffers the elastic buffer's valid-only stream in a small FIFO and
// re-emits it as valid/ready. Optional skip-beat filter enabled by `define RD_STREAM_SKP_FILTER_EN.
module rd_stream_out_stage #(
   parameter int                    DATA_WIDTH  = 20,
   parameter int                    LANES       = 1,
   parameter int                    DEPTH       = 4,
   parameter logic [DATA_WIDTH-1:0] SKP_PATTERN = 20'h0_F1C2
) (
   input  logic                           clk,
   input  logic                           arst_n,
   input  logic [LANES*DATA_WIDTH-1:0]    in_data,
   input  logic                           in_vld,
   output logic                           in_rdy,
   output logic [LANES*DATA_WIDTH-1:0]    out_data,
   output logic                           out_vld,
   input  logic                           out_rdy,
   output logic [$clog2(DEPTH+1)-1:0]     level,
   output logic                           ovf_err,
   input  logic                           ovf_clr,
   output logic                           skp_drop
);

   localparam int W  = LANES * DATA_WIDTH;
   localparam int PW = $clog2(DEPTH);
   localparam int LW = $clog2(DEPTH + 1);
   localparam logic [LW-1:0] FULL_LVL = LW'(DEPTH);

   function automatic logic is_skp(input logic [W-1:0] beat);
      logic hit;
      hit = 1'b1;
      for (int k = 0; k < LANES; k++) begin
         if (beat[k*DATA_WIDTH +: DATA_WIDTH] != SKP_PATTERN) hit = 1'b0;
      end
      return hit;
   endfunction

   logic [W-1:0]  mem [DEPTH];
   logic [W-1:0]  last_q;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [LW-1:0] level_q;
   logic          ovf_q;
   logic          skp_hit;
   logic          skp_beat;
   logic          push;
   logic          pop;
   logic          ovf_set;

   assign skp_hit = is_skp(in_data);

`ifdef RD_STREAM_SKP_FILTER_EN
   logic skp_q;

   assign skp_beat = in_vld && skp_hit;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) skp_q <= 1'b0;
      else         skp_q <= skp_beat;
   end

   assign skp_drop = skp_q;
`else
   logic unused_skp;

   assign unused_skp = skp_hit;
   assign skp_beat   = 1'b0;
   assign skp_drop   = 1'b0;
`endif

   // Flow control depends on registered occupancy only, so in_rdy never sees out_rdy.
   assign in_rdy  = (level_q != FULL_LVL);
   assign out_vld = (level_q != '0);
   assign push    = in_vld && in_rdy && !skp_beat;
   assign pop     = out_vld && out_rdy;
   assign ovf_set = in_vld && !in_rdy && !skp_beat;

   assign level    = level_q;
   assign ovf_err  = ovf_q;
   assign out_data = out_vld ? mem[rd_ptr] : last_q;

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else if (push) begin
         mem[wr_ptr] <= in_data;
      end
   end

   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         level_q <= '0;
         last_q  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
            last_q <= mem[rd_ptr];
         end
         case ({push, pop})
            2'b10:   level_q <= level_q + LW'(1);
            2'b01:   level_q <= level_q - LW'(1);
            default: level_q <= level_q;
         endcase
      end
   end

   // A set in the same cycle as a clear takes priority so no drop goes unreported.
   always_ff @(posedge clk or negedge arst_n) begin
      if (!arst_n)      ovf_q <= 1'b0;
      else if (ovf_set) ovf_q <= 1'b1;
      else if (ovf_clr) ovf_q <= 1'b0;
   end

endmodule

// File: tb/tb_rd_stream_out_stage.sv
// Self-checking bench for rd_stream_out_stage: vector table plus scoreboard of expected beats.
module tb_rd_stream_out_stage;

   localparam int DW    = 20;
   localparam int LN    = 2;
   localparam int DEPTH = 4;
   localparam int W     = DW * LN;
   localparam int LW    = $clog2(DEPTH + 1);
   localparam logic [DW-1:0] SKP = 20'h0_F1C2;
`ifdef RD_STREAM_SKP_FILTER_EN
   localparam bit FILT = 1'b1;
`else
   localparam bit FILT = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          arst_n;
   logic [W-1:0]  in_data;
   logic          in_vld;
   logic          in_rdy;
   logic [W-1:0]  out_data;
   logic          out_vld;
   logic          out_rdy;
   logic [LW-1:0] level;
   logic          ovf_err;
   logic          ovf_clr;
   logic          skp_drop;

   rd_stream_out_stage #(
      .DATA_WIDTH(DW), .LANES(LN), .DEPTH(DEPTH), .SKP_PATTERN(SKP)
   ) dut (
      .clk(clk), .arst_n(arst_n), .in_data(in_data), .in_vld(in_vld), .in_rdy(in_rdy),
      .out_data(out_data), .out_vld(out_vld), .out_rdy(out_rdy), .level(level),
      .ovf_err(ovf_err), .ovf_clr(ovf_clr), .skp_drop(skp_drop)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic         vld;
      logic [W-1:0] d;
      logic         rdy;
      logic         clr;
      int           lvl;
      logic         ovf;
   } vec_t;

   vec_t         tbl[$];
   logic [W-1:0] sb[$];
   int           m_lvl;
   logic         m_ovf;
   logic [W-1:0] m_last;
   int           n_chk;
   int           n_fail;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic add_vec(input logic vld, input logic [W-1:0] d, input logic rdy,
                          input logic clr, input int lvl, input logic ovf);
      vec_t v;
      v.vld = vld; v.d = d; v.rdy = rdy; v.clr = clr; v.lvl = lvl; v.ovf = ovf;
      tbl.push_back(v);
   endtask

   task automatic model_reset();
      sb.delete();
      m_lvl  = 0;
      m_ovf  = 1'b0;
      m_last = '0;
   endtask

   // One clock: drive at negedge, check pre-edge head against scoreboard, check state after edge.
   task automatic step(input logic vld, input logic [W-1:0] d, input logic rdy, input logic clr);
      logic skp, push, pop;
      @(negedge clk);
      in_vld = vld; in_data = d; out_rdy = rdy; ovf_clr = clr;
      #1;
      skp  = FILT && vld && (d == {LN{SKP}});
      push = vld && (m_lvl != DEPTH) && !skp;
      pop  = rdy && (m_lvl != 0);
      check("in_rdy", in_rdy, m_lvl != DEPTH);
      check("out_vld", out_vld, m_lvl != 0);
      if (m_lvl != 0) check("out_data", out_data, sb[0]);
      else            check("out_data_idle", out_data, m_last);
      if (pop) m_last = sb.pop_front();
      if (push) sb.push_back(d);
      if (vld && (m_lvl == DEPTH) && !skp) m_ovf = 1'b1;
      else if (clr)                         m_ovf = 1'b0;
      m_lvl = m_lvl + (push ? 1 : 0) - (pop ? 1 : 0);
      @(posedge clk);
      #1;
      check("level", level, m_lvl);
      check("ovf_err", ovf_err, m_ovf);
      check("skp_drop", skp_drop, skp);
   endtask

   function automatic logic [W-1:0] beat(input int n);
      return {DW'(n + 32'h100), DW'(n)};
   endfunction

   initial begin
      n_chk = 0; n_fail = 0;
      arst_n = 1'b0; in_vld = 1'b0; in_data = '0; out_rdy = 1'b0; ovf_clr = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      @(negedge clk);
      arst_n = 1'b1;
      #1;
      check("rst_level", level, 0);
      check("rst_out_vld", out_vld, 0);
      check("rst_in_rdy", in_rdy, 1);
      check("rst_ovf", ovf_err, 0);
      check("rst_out_data", out_data, 0);
      check("rst_skp_drop", skp_drop, 0);

      // Single two-lane beat, lane 0 in LSBs.
      step(1'b1, 40'h12345_ABCDE, 1'b1, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);
      check("single_empty_hold", out_data, 40'h12345_ABCDE);

      // Fill, overflow, drain, clear; then full-with-pop drop, set-vs-clear priority.
      for (int i = 1; i <= 6; i++) add_vec(1'b1, beat(i), 1'b0, 1'b0, (i > 4) ? 4 : i, i > 4);
      for (int i = 3; i >= 0; i--) add_vec(1'b0, '0, 1'b1, 1'b0, i, 1'b1);
      add_vec(1'b0, '0, 1'b0, 1'b1, 0, 1'b0);
      for (int i = 1; i <= 4; i++) add_vec(1'b1, beat(10 + i), 1'b0, 1'b0, i, 1'b0);
      add_vec(1'b1, beat(15), 1'b1, 1'b0, 3, 1'b1);
      add_vec(1'b1, beat(16), 1'b0, 1'b0, 4, 1'b1);
      add_vec(1'b0, '0, 1'b0, 1'b1, 4, 1'b0);
      add_vec(1'b1, beat(17), 1'b0, 1'b1, 4, 1'b1);
      add_vec(1'b0, '0, 1'b0, 1'b1, 4, 1'b0);
      for (int i = 3; i >= 0; i--) add_vec(1'b0, '0, 1'b1, 1'b0, i, 1'b0);
      foreach (tbl[i]) begin
         step(tbl[i].vld, tbl[i].d, tbl[i].rdy, tbl[i].clr);
         check("tbl_level", level, tbl[i].lvl);
         check("tbl_ovf", ovf_err, tbl[i].ovf);
      end
      check("drain_hold", out_data, beat(16));

      // Continuous flow across several pointer wraps; occupancy stays at one.
      step(1'b1, beat(40), 1'b1, 1'b0);
      for (int i = 0; i < 3 * DEPTH; i++) begin
         step(1'b1, beat(41 + i) ^ 40'(i * 32'h9E37), 1'b1, 1'b0);
         check("flow_level", level, 1);
      end
      step(1'b0, '0, 1'b1, 1'b0);

      // Skip beat between two data beats, and a skip beat arriving while full.
      step(1'b1, beat(60), 1'b0, 1'b0);
      step(1'b1, {LN{SKP}}, 1'b0, 1'b0);
      step(1'b1, beat(61), 1'b0, 1'b0);
      step(1'b1, beat(62), 1'b0, 1'b0);
      step(1'b1, beat(63), 1'b0, 1'b0);
      step(1'b1, {LN{SKP}}, 1'b0, 1'b0);
      step(1'b0, '0, 1'b0, 1'b1);
      repeat (5) step(1'b0, '0, 1'b1, 1'b0);

      // Asynchronous reset in the middle of a stream.
      step(1'b1, beat(70), 1'b0, 1'b0);
      step(1'b1, beat(71), 1'b0, 1'b0);
      @(negedge clk);
      in_vld = 1'b0;
      #2;
      arst_n = 1'b0;
      #1;
      check("mid_rst_level", level, 0);
      check("mid_rst_out_vld", out_vld, 0);
      check("mid_rst_out_data", out_data, 0);
      check("mid_rst_in_rdy", in_rdy, 1);
      model_reset();
      @(negedge clk);
      arst_n = 1'b1;
      step(1'b1, beat(80), 1'b0, 1'b0);
      step(1'b0, '0, 1'b1, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
